// File: rtl/stream_frame_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_frame_check: 2-cycle fval/lval/data pass-through with per-frame     |
// | line/pixel geometry checks. Option: STREAM_FRAME_CHECK_STICKY_EN.  Rev 1.0 |
// +----------------------------------------------------------------------------+
module stream_frame_check #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 1,
  parameter int REG_WD      = 32,
  parameter int CNT_WD      = 16
) (
  input  logic                              clk_pix,
  input  logic                              reset_pix_n,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic [REG_WD-1:0]                 iv_width_expect,
  input  logic [REG_WD-1:0]                 iv_height_expect,
`ifdef STREAM_FRAME_CHECK_STICKY_EN
  input  logic                              i_err_clr,
  output logic                              o_err_sticky,
`endif
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic [CNT_WD-1:0]                 ov_frame_width,
  output logic [CNT_WD-1:0]                 ov_frame_height,
  output logic                              o_width_err,
  output logic                              o_height_err,
  output logic [REG_WD-1:0]                 ov_frame_cnt,
  output logic [REG_WD-1:0]                 ov_err_frame_cnt
);

  localparam int                PW      = DATA_WIDTH * CHANNEL_NUM;
  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);
  localparam logic [REG_WD-1:0] REG_ONE = REG_WD'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              valid1_q, valid1_d;
  logic              fval1_q, fval1_d, lval1_q, lval1_d;
  logic              fval2_q, fval2_d, lval2_q, lval2_d;
  logic [PW-1:0]     data1_q, data1_d, data_out_q, data_out_d;
  logic              fval_out_q, fval_out_d, lval_out_q, lval_out_d;
  logic [CNT_WD-1:0] exp_w_q, exp_w_d, exp_h_q, exp_h_d;
  logic [CNT_WD-1:0] pix_q, pix_d, line_q, line_d, wmax_q, wmax_d;
  logic              werr_acc_q, werr_acc_d;
  logic              done_q, done_d;
  logic [CNT_WD-1:0] width_q, width_d, height_q, height_d;
  logic              werr_q, werr_d, herr_q, herr_d;
  logic [REG_WD-1:0] fcnt_q, fcnt_d, efcnt_q, efcnt_d;
  logic              g1, g2, f_rise, f_fall;

  logic w_unused_expect_hi;
  assign w_unused_expect_hi = ^{iv_width_expect[REG_WD-1:CNT_WD], iv_height_expect[REG_WD-1:CNT_WD]};

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    // A pixel exists only where both fval and lval are high; lines are runs of that.
    g1     = fval1_q & lval1_q;
    g2     = fval2_q & lval2_q;
    f_rise = fval1_q & ~fval2_q;
    f_fall = ~fval1_q & fval2_q;

    valid1_d   = 1'b1;
    fval1_d    = i_fval;
    lval1_d    = i_lval;
    data1_d    = iv_pix_data;
    fval2_d    = fval1_q;
    lval2_d    = lval1_q;
    data_out_d = data1_q;
    fval_out_d = fval1_q & (state_q != S_IDLE);
    lval_out_d = lval1_q & fval1_q & (state_q != S_IDLE);

    state_d    = state_q;
    exp_w_d    = exp_w_q;
    exp_h_d    = exp_h_q;
    pix_d      = pix_q;
    line_d     = line_q;
    wmax_d     = wmax_q;
    werr_acc_d = werr_acc_q;
    done_d     = 1'b0;
    width_d    = width_q;
    height_d   = height_q;
    werr_d     = werr_q;
    herr_d     = herr_q;
    fcnt_d     = fcnt_q;
    efcnt_d    = efcnt_q;

    case (state_q)
      S_IDLE: begin
        if (valid1_q && !fval1_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (f_rise) begin
          state_d    = S_FRAME;
          exp_w_d    = iv_width_expect[CNT_WD-1:0];
          exp_h_d    = iv_height_expect[CNT_WD-1:0];
          pix_d      = lval1_q ? CNT_ONE : '0;
          line_d     = '0;
          wmax_d     = '0;
          werr_acc_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (g1) pix_d = g2 ? sat_inc(pix_q) : CNT_ONE;
        if (g2 && !g1) begin
          line_d = sat_inc(line_q);
          if (pix_q > wmax_q) wmax_d = pix_q;
          if ((exp_w_q != '0) && (pix_q != exp_w_q)) werr_acc_d = 1'b1;
        end
        // Status is loaded on the edge into S_DONE so it is valid alongside the done pulse.
        if (f_fall) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          width_d  = wmax_d;
          height_d = line_d;
          werr_d   = werr_acc_d;
          herr_d   = (exp_h_q != '0) && (line_d != exp_h_q);
          fcnt_d   = fcnt_q + REG_ONE;
          if (werr_acc_d || herr_d) efcnt_d = efcnt_q + REG_ONE;
        end
      end
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      state_q    <= S_IDLE;
      valid1_q   <= 1'b0;
      fval1_q    <= 1'b0;
      lval1_q    <= 1'b0;
      fval2_q    <= 1'b0;
      lval2_q    <= 1'b0;
      data1_q    <= '0;
      data_out_q <= '0;
      fval_out_q <= 1'b0;
      lval_out_q <= 1'b0;
      exp_w_q    <= '0;
      exp_h_q    <= '0;
      pix_q      <= '0;
      line_q     <= '0;
      wmax_q     <= '0;
      werr_acc_q <= 1'b0;
      done_q     <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      werr_q     <= 1'b0;
      herr_q     <= 1'b0;
      fcnt_q     <= '0;
      efcnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid1_q   <= valid1_d;
      fval1_q    <= fval1_d;
      lval1_q    <= lval1_d;
      fval2_q    <= fval2_d;
      lval2_q    <= lval2_d;
      data1_q    <= data1_d;
      data_out_q <= data_out_d;
      fval_out_q <= fval_out_d;
      lval_out_q <= lval_out_d;
      exp_w_q    <= exp_w_d;
      exp_h_q    <= exp_h_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      wmax_q     <= wmax_d;
      werr_acc_q <= werr_acc_d;
      done_q     <= done_d;
      width_q    <= width_d;
      height_q   <= height_d;
      werr_q     <= werr_d;
      herr_q     <= herr_d;
      fcnt_q     <= fcnt_d;
      efcnt_q    <= efcnt_d;
    end
  end

`ifdef STREAM_FRAME_CHECK_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == S_DONE) && (werr_q || herr_q)) sticky_d = 1'b1;
    else if (i_err_clr)                              sticky_d = 1'b0;
  end

  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) sticky_q <= 1'b0;
    else              sticky_q <= sticky_d;
  end

  assign o_err_sticky = sticky_q;
`endif

  assign o_fval           = fval_out_q;
  assign o_lval           = lval_out_q;
  assign ov_pix_data      = data_out_q;
  assign o_frame_done     = done_q;
  assign ov_frame_width   = width_q;
  assign ov_frame_height  = height_q;
  assign o_width_err      = werr_q;
  assign o_height_err     = herr_q;
  assign ov_frame_cnt     = fcnt_q;
  assign ov_err_frame_cnt = efcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_frame_check.sv
`default_nettype none
// tb_stream_frame_check: table-driven frames, corner sequences and random frames
// checked against a frame-level reference model.
module tb_stream_frame_check;
  localparam int DW = 10;
  localparam int RW = 32;
  localparam int CW = 16;

  logic          clk_pix = 1'b0;
  logic          reset_pix_n = 1'b0;
  logic          i_fval = 1'b0, i_lval = 1'b0;
  logic [DW-1:0] iv_pix_data = '0;
  logic [RW-1:0] iv_width_expect = '0, iv_height_expect = '0;
  logic          o_fval, o_lval, o_frame_done, o_width_err, o_height_err;
  logic [DW-1:0] ov_pix_data;
  logic [CW-1:0] ov_frame_width, ov_frame_height;
  logic [RW-1:0] ov_frame_cnt, ov_err_frame_cnt;
`ifdef STREAM_FRAME_CHECK_STICKY_EN
  logic          i_err_clr = 1'b0;
  logic          o_err_sticky;
`endif

  always #5 clk_pix = ~clk_pix;

  stream_frame_check #(.DATA_WIDTH(DW), .CHANNEL_NUM(1), .REG_WD(RW), .CNT_WD(CW)) dut (
    .clk_pix(clk_pix), .reset_pix_n(reset_pix_n), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(iv_pix_data), .iv_width_expect(iv_width_expect), .iv_height_expect(iv_height_expect),
`ifdef STREAM_FRAME_CHECK_STICKY_EN
    .i_err_clr(i_err_clr), .o_err_sticky(o_err_sticky),
`endif
    .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(ov_pix_data), .o_frame_done(o_frame_done),
    .ov_frame_width(ov_frame_width), .ov_frame_height(ov_frame_height),
    .o_width_err(o_width_err), .o_height_err(o_height_err),
    .ov_frame_cnt(ov_frame_cnt), .ov_err_frame_cnt(ov_err_frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct { int w; int h; bit we; bit he; } frame_t;
  frame_t        exp_q[$];
  frame_t        fr;
  bit            chk_out = 1'b1;
  bit            armed, in_frame, prev_f, prev_g;
  int            run, lines, maxw, ew, eh, m_fc, m_efc, done_cnt;
  bit            we;
  logic          f_d1, f_d2, l_d1, l_d2;
  logic [DW-1:0] d_d1, d_d2;

  always @(negedge clk_pix) begin
    if (!reset_pix_n) begin
      exp_q.delete();
      armed = 0; in_frame = 0; prev_f = 0; prev_g = 0;
      m_fc = 0; m_efc = 0;
      f_d1 = 0; f_d2 = 0; l_d1 = 0; l_d2 = 0; d_d1 = '0; d_d2 = '0;
    end else begin
      if (chk_out) begin
        chk("o_fval", o_fval, f_d2);
        chk("o_lval", o_lval, f_d2 & l_d2);
        chk("ov_pix_data", ov_pix_data, d_d2);
      end
      if (o_frame_done) begin
        done_cnt++;
        chk("frame_expected_at_done", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          fr = exp_q.pop_front();
          m_fc++;
          if (fr.we || fr.he) m_efc++;
          chk("model_width", ov_frame_width, fr.w);
          chk("model_height", ov_frame_height, fr.h);
          chk("model_width_err", o_width_err, fr.we);
          chk("model_height_err", o_height_err, fr.he);
          chk("model_frame_cnt", ov_frame_cnt, m_fc);
          chk("model_err_frame_cnt", ov_err_frame_cnt, m_efc);
        end
      end
      if (!armed) begin
        if (!i_fval) armed = 1;
      end else if (!in_frame) begin
        if (i_fval && !prev_f) begin
          in_frame = 1;
          ew = int'(iv_width_expect & 32'hFFFF);
          eh = int'(iv_height_expect & 32'hFFFF);
          run = i_lval ? 1 : 0; lines = 0; maxw = 0; we = 0;
        end
      end else begin
        if (i_fval && i_lval) run = prev_g ? ((run < 65535) ? run + 1 : run) : 1;
        if (prev_g && !(i_fval && i_lval)) begin
          if (lines < 65535) lines++;
          if (run > maxw) maxw = run;
          if (ew != 0 && run != ew) we = 1;
        end
        if (!i_fval) begin
          in_frame = 0;
          exp_q.push_back('{maxw, lines, we, (eh != 0 && lines != eh)});
        end
      end
      prev_f = i_fval;
      prev_g = i_fval & i_lval;
      f_d2 = f_d1; l_d2 = l_d1; d_d2 = d_d1;
      f_d1 = i_fval; l_d1 = i_lval; d_d1 = iv_pix_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit f, input bit l);
    i_fval = f;
    i_lval = l;
    iv_pix_data = DW'($urandom);
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic frame(input int nlines, input int width, input int odd_line, input int odd_len);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    for (int i = 0; i < nlines; i++) begin
      int len;
      len = (i == odd_line) ? odd_len : width;
      repeat (len) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0);
  endtask

  typedef struct {
    int reps; int lines; int width; int odd_line; int odd_len; int ew; int eh;
    int xw; int xh; bit xwe; bit xhe; int xfc; int xefc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int dc0;
    tbl[0] = '{10, 64, 64, -1,  0, 64,        64,        64, 64, 1'b0, 1'b0, 10, 0};
    tbl[1] = '{ 1, 63, 64, -1,  0, 64,        64,        64, 63, 1'b0, 1'b1, 11, 1};
    tbl[2] = '{ 1, 64, 64, -1,  0, 32'h10040, 32'h20040, 64, 64, 1'b0, 1'b0, 12, 1};
    tbl[3] = '{ 1, 64, 64, 10, 65, 64,        64,        65, 64, 1'b1, 1'b0, 13, 2};
    tbl[4] = '{ 1, 64, 64, 10, 65, 0,         64,        65, 64, 1'b0, 1'b0, 14, 2};
    tbl[5] = '{ 1,  0, 64, -1,  0, 64,        64,         0,  0, 1'b0, 1'b1, 15, 3};
    tbl[6] = '{ 1,  0, 64, -1,  0, 0,         0,          0,  0, 1'b0, 1'b0, 16, 3};

    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_o_fval", o_fval, 0);
    chk("rst_o_lval", o_lval, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_width", ov_frame_width, 0);
    chk("rst_height", ov_frame_height, 0);
    chk("rst_width_err", o_width_err, 0);
    chk("rst_height_err", o_height_err, 0);
    chk("rst_frame_cnt", ov_frame_cnt, 0);
    chk("rst_err_frame_cnt", ov_err_frame_cnt, 0);
    reset_pix_n = 1'b1;
    idle(3);

    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        iv_width_expect  = tbl[r].ew;
        iv_height_expect = tbl[r].eh;
        idle(3);
        dc0 = done_cnt;
        frame(tbl[r].lines, tbl[r].width, tbl[r].odd_line, tbl[r].odd_len);
        idle(4);
        chk("tbl_done_pulses", done_cnt - dc0, 1);
        chk("tbl_width", ov_frame_width, tbl[r].xw);
        chk("tbl_height", ov_frame_height, tbl[r].xh);
        chk("tbl_width_err", o_width_err, tbl[r].xwe);
        chk("tbl_height_err", o_height_err, tbl[r].xhe);
      end
      chk("tbl_frame_cnt", ov_frame_cnt, tbl[r].xfc);
      chk("tbl_err_frame_cnt", ov_err_frame_cnt, tbl[r].xefc);
    end

    // Stray lval outside fval, then a frame whose last line is cut by fval falling.
    iv_width_expect = 64; iv_height_expect = 3;
    repeat (2) begin repeat (8) cyc(1'b0, 1'b1); idle(2); end
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    repeat (3) begin repeat (64) cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); end
    repeat (30) cyc(1'b1, 1'b1);
    repeat (8) cyc(1'b0, 1'b1);
    idle(4);
    chk("trunc_width", ov_frame_width, 64);
    chk("trunc_height", ov_frame_height, 4);
    chk("trunc_width_err", o_width_err, 1);
    chk("trunc_height_err", o_height_err, 1);
    chk("trunc_frame_cnt", ov_frame_cnt, 17);

    // Reset asserted mid-frame and released while fval is still high.
    iv_width_expect = 4; iv_height_expect = 2;
    chk_out = 1'b0;
    cyc(1'b1, 1'b0); repeat (4) cyc(1'b1, 1'b1);
    reset_pix_n = 1'b0;
    #1;
    chk("async_rst_frame_cnt", ov_frame_cnt, 0);
    chk("async_rst_o_fval", o_fval, 0);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    reset_pix_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, (i % 6) < 4);
      chk("partial_o_fval", o_fval, 0);
      chk("partial_o_lval", o_lval, 0);
    end
    cyc(1'b0, 1'b0);
    idle(4);
    chk("partial_frame_cnt", ov_frame_cnt, 0);
    chk_out = 1'b1;
    frame(2, 4, -1, 0);
    idle(4);
    chk("after_rst_frame_cnt", ov_frame_cnt, 1);
    chk("after_rst_height", ov_frame_height, 2);
    chk("after_rst_err", {o_width_err, o_height_err}, 0);

    // Randomized frames; the model scoreboard checks every frame_done.
    for (int n = 0; n < 30; n++) begin
      int nl, len, sel;
      bit trunc;
      sel = int'($urandom_range(0, 3));
      iv_width_expect  = (sel == 0) ? 0 : (sel == 1) ? 4 : (sel == 2) ? 6 : $urandom_range(1, 10);
      iv_height_expect = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) cyc(1'b0, 1'b1);
      idle(3);
      repeat ($urandom_range(1, 2)) cyc(1'b1, 1'b0);
      nl = int'($urandom_range(0, 5));
      trunc = (nl > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < nl; i++) begin
        len = ($urandom_range(0, 1) == 1 && iv_width_expect != 0) ? int'(iv_width_expect) : int'($urandom_range(1, 10));
        repeat (len) cyc(1'b1, 1'b1);
        if (!(trunc && i == nl - 1)) repeat ($urandom_range(1, 3)) cyc(1'b1, 1'b0);
      end
      if (trunc) cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      idle(3);
    end
    idle(4);
    chk("random_frames_drained", exp_q.size(), 0);
    chk("random_frame_cnt", ov_frame_cnt, m_fc);

`ifdef STREAM_FRAME_CHECK_STICKY_EN
    i_err_clr = 1'b1; cyc(1'b0, 1'b0); i_err_clr = 1'b0;
    chk("sticky_cleared0", o_err_sticky, 0);
    iv_width_expect = 4; iv_height_expect = 3;
    idle(3); frame(2, 4, -1, 0); idle(4);
    chk("sticky_set", o_err_sticky, 1);
    iv_height_expect = 2;
    idle(3); frame(2, 4, -1, 0); idle(4);
    chk("sticky_good_frame_herr", o_height_err, 0);
    chk("sticky_held", o_err_sticky, 1);
    i_err_clr = 1'b1; cyc(1'b0, 1'b0); i_err_clr = 1'b0;
    cyc(1'b0, 1'b0);
    chk("sticky_cleared", o_err_sticky, 0);
    iv_height_expect = 3;
    idle(3); frame(2, 4, -1, 0);
    cyc(1'b0, 1'b0);
    i_err_clr = 1'b1; cyc(1'b0, 1'b0); i_err_clr = 1'b0;
    idle(3);
    chk("sticky_set_priority", o_err_sticky, 1);
`endif

    idle(3);
    chk("final_frames_drained", exp_q.size(), 0);
    chk("final_err_frame_cnt", ov_err_frame_cnt, m_efc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
